// File: rtl/alu4_op_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu4_op_sequencer_pkg
//  Purpose  : Opcode constants and FSM state encoding shared by the 4-bit
//             ALU operation sequencer and its test environment.
//  Revision : 1.0 - initial release
// ============================================================================
package alu4_op_sequencer_pkg;

  // Opcode encoding presented on reqOp
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_NEG = 2'b10;
  localparam logic [1:0] OP_ABS = 2'b11;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_NEGATE = 2'd1,
    ST_ADD    = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu4_adder4.sv
`default_nettype none
// ============================================================================
//  Module   : alu4_adder4
//  Purpose  : Purely combinational 4-bit adder. Bit 4 of the sum is the
//             unsigned carry out.
//  Revision : 1.0 - initial release
// ============================================================================
module alu4_adder4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [4:0] sum_o
);

  // Zero-extend both operands so the carry lands in bit 4
  assign sum_o = {1'b0, a_i} + {1'b0, b_i};

endmodule
`default_nettype wire

// File: rtl/alu4_negator4.sv
`default_nettype none
// ============================================================================
//  Module   : alu4_negator4
//  Purpose  : 4-bit two's-complement negator (y = -a). The negation of
//             1000 wraps to 1000; callers flag that case as overflow.
//  Revision : 1.0 - initial release
// ============================================================================
module alu4_negator4 (
  input  logic [3:0] a_i,
  output logic [3:0] y_o
);

  // Invert and add one
  assign y_o = (~a_i) + 4'd1;

endmodule
`default_nettype wire

// File: rtl/alu4_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu4_op_sequencer
//  Purpose  : Multi-cycle controller executing ADD/SUB/NEG/ABS on 4-bit
//             two's-complement operands using one shared negator and one
//             shared adder. Valid/ready on both request and response sides.
//  Revision : 1.0 - initial release
// ============================================================================
module alu4_op_sequencer
  import alu4_op_sequencer_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             reqValid,
  output logic             reqReady,
  input  logic [1:0]       reqOp,
  input  logic [3:0]       reqA,
  input  logic [3:0]       reqB,
  output logic             respValid,
  input  logic             respReady,
  output logic [3:0]       respResult,
  output logic             respCarry,
  output logic             respOverflow,
  output logic             respZero,
  output logic             respNeg,
  output logic [CNT_W-1:0] opCount
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q;
  logic [1:0]       op_q;
  logic [3:0]       a_q;
  logic [3:0]       b_q;
  logic [3:0]       opb_q;      // negated B, captured in NEGATE for SUB
  logic [3:0]       result_q;
  logic             carry_q;
  logic             ovf_q;
  logic             zero_q;
  logic             neg_q;
  logic [CNT_W-1:0] count_q;

  logic [3:0]       neg_in;
  logic [3:0]       neg_out;
  logic [3:0]       add_b;
  logic [4:0]       sum;
  logic [3:0]       unary_res;
  logic             add_ovf;

  alu4_negator4 u_neg (
    .a_i (neg_in),
    .y_o (neg_out)
  );

  alu4_adder4 u_add (
    .a_i   (a_q),
    .b_i   (add_b),
    .sum_o (sum)
  );

  // Operand steering for the shared units and overflow of the add step.
  // SUB overflow is judged against the original B so that B=1000 (whose
  // negation wraps to itself) still reports the true signed overflow.
  always_comb begin
    neg_in    = (op_q == OP_SUB) ? b_q : a_q;
    add_b     = (op_q == OP_SUB) ? opb_q : b_q;
    unary_res = ((op_q == OP_ABS) && !a_q[3]) ? a_q : neg_out;
    if (op_q == OP_SUB) begin
      add_ovf = (a_q[3] != b_q[3]) && (sum[3] != a_q[3]);
    end else begin
      add_ovf = (a_q[3] == b_q[3]) && (sum[3] != a_q[3]);
    end
  end

  // Sequencer FSM with operand, result, flag and counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= 2'b00;
      a_q      <= 4'b0000;
      b_q      <= 4'b0000;
      opb_q    <= 4'b0000;
      result_q <= 4'b0000;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (reqValid) begin
            op_q    <= reqOp;
            a_q     <= reqA;
            b_q     <= reqB;
            state_q <= (reqOp == OP_ADD) ? ST_ADD : ST_NEGATE;
          end
        end
        ST_NEGATE: begin
          if (op_q == OP_SUB) begin
            opb_q   <= neg_out;
            state_q <= ST_ADD;
          end else begin
            result_q <= unary_res;
            carry_q  <= 1'b0;
            ovf_q    <= (a_q == 4'b1000);
            zero_q   <= (unary_res == 4'b0000);
            neg_q    <= unary_res[3];
            state_q  <= ST_RESP;
          end
        end
        ST_ADD: begin
          result_q <= sum[3:0];
          carry_q  <= sum[4];
          ovf_q    <= add_ovf;
          zero_q   <= (sum[3:0] == 4'b0000);
          neg_q    <= sum[3];
          state_q  <= ST_RESP;
        end
        ST_RESP: begin
          if (respReady) begin
            count_q <= count_q + CNT_ONE;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign reqReady     = (state_q == ST_IDLE);
  assign respValid    = (state_q == ST_RESP);
  assign respResult   = result_q;
  assign respCarry    = carry_q;
  assign respOverflow = ovf_q;
  assign respZero     = zero_q;
  assign respNeg      = neg_q;
  assign opCount      = count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu4_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu4_op_sequencer
//  Purpose  : Directed self-checking bench for alu4_op_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu4_op_sequencer;
  import alu4_op_sequencer_pkg::*;

  localparam int CNT_W = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             reqValid = 1'b0;
  logic             reqReady;
  logic [1:0]       reqOp = 2'b00;
  logic [3:0]       reqA = 4'b0000;
  logic [3:0]       reqB = 4'b0000;
  logic             respValid;
  logic             respReady = 1'b1;
  logic [3:0]       respResult;
  logic             respCarry;
  logic             respOverflow;
  logic             respZero;
  logic             respNeg;
  logic [CNT_W-1:0] opCount;

  int n_tests = 0;
  int n_fail  = 0;

  alu4_op_sequencer #(.CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .reqValid     (reqValid),
    .reqReady     (reqReady),
    .reqOp        (reqOp),
    .reqA         (reqA),
    .reqB         (reqB),
    .respValid    (respValid),
    .respReady    (respReady),
    .respResult   (respResult),
    .respCarry    (respCarry),
    .respOverflow (respOverflow),
    .respZero     (respZero),
    .respNeg      (respNeg),
    .opCount      (opCount)
  );

  always #5 clock = ~clock;

  // Issue one request and count edges (acceptance edge = 1) until respValid.
  // lat = 0 means the response never appeared within the budget.
  task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                      output int lat);
    int guard;
    guard = 0;
    while (!reqReady && guard < 20) begin
      @(posedge clock); #1; guard++;
    end
    reqValid = 1'b1; reqOp = op; reqA = a; reqB = b;
    @(posedge clock); #1;
    reqValid = 1'b0;
    lat = 1;
    while (!respValid && lat < 20) begin
      @(posedge clock); #1; lat++;
    end
    if (!respValid) lat = 0;
  endtask

  // Complete the response handshake
  task automatic finish_resp;
    respReady = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_tests++;
    if ({reqReady, respValid} !== 2'b10) begin
      n_fail++; $display("FAIL reset_hs: got rdy/vld %b need 10", {reqReady, respValid});
    end
    n_tests++;
    if ({respResult, respCarry, respOverflow, respZero, respNeg} !== 8'h00) begin
      n_fail++; $display("FAIL reset_res: got %b need 00000000",
                         {respResult, respCarry, respOverflow, respZero, respNeg});
    end
    n_tests++;
    if (opCount !== 8'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d need 0", opCount);
    end
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_add;
    int lat;
    respReady = 1'b1;
    send(OP_ADD, 4'b0011, 4'b0100, lat);
    n_tests++;
    if (lat !== 2) begin n_fail++; $display("FAIL add_lat: got %0d need 2", lat); end
    n_tests++;
    if (respResult !== 4'b0111) begin n_fail++; $display("FAIL add_res: got %b need 0111", respResult); end
    n_tests++;
    if ({respCarry, respOverflow, respZero, respNeg} !== 4'b0000) begin
      n_fail++; $display("FAIL add_flags: got %b need 0000", {respCarry, respOverflow, respZero, respNeg});
    end
    finish_resp();
    n_tests++;
    if ({opCount, respValid, reqReady} !== {8'd1, 2'b01}) begin
      n_fail++; $display("FAIL add_cnt: got cnt %0d vld %b rdy %b need 1 0 1", opCount, respValid, reqReady);
    end
    // carry out with zero result
    send(OP_ADD, 4'b1111, 4'b0001, lat);
    n_tests++;
    if ({respResult, respCarry, respOverflow, respZero, respNeg} !== 8'b0000_1010) begin
      n_fail++; $display("FAIL add_carry: got %b need 00001010",
                         {respResult, respCarry, respOverflow, respZero, respNeg});
    end
    finish_resp();
  endtask

  task automatic test_sub;
    int lat;
    send(OP_SUB, 4'b0010, 4'b0101, lat);
    n_tests++;
    if (lat !== 3) begin n_fail++; $display("FAIL sub_lat: got %0d need 3", lat); end
    n_tests++;
    if ({respResult, respCarry, respOverflow, respZero, respNeg} !== 8'b1101_0001) begin
      n_fail++; $display("FAIL sub_2m5: got %b need 11010001",
                         {respResult, respCarry, respOverflow, respZero, respNeg});
    end
    finish_resp();
    send(OP_SUB, 4'b0000, 4'b1000, lat);
    n_tests++;
    if ({respResult, respCarry, respOverflow, respZero, respNeg} !== 8'b1000_0101) begin
      n_fail++; $display("FAIL sub_0m8: got %b need 10000101",
                         {respResult, respCarry, respOverflow, respZero, respNeg});
    end
    finish_resp();
    send(OP_SUB, 4'b0101, 4'b0011, lat);
    n_tests++;
    if ({respResult, respCarry, respOverflow, respZero, respNeg} !== 8'b0010_1000) begin
      n_fail++; $display("FAIL sub_5m3: got %b need 00101000",
                         {respResult, respCarry, respOverflow, respZero, respNeg});
    end
    finish_resp();
  endtask

  task automatic test_neg_abs;
    int lat;
    send(OP_NEG, 4'b1000, 4'b0000, lat);
    n_tests++;
    if (lat !== 2) begin n_fail++; $display("FAIL neg_lat: got %0d need 2", lat); end
    n_tests++;
    if ({respResult, respCarry, respOverflow, respZero, respNeg} !== 8'b1000_0101) begin
      n_fail++; $display("FAIL neg_min: got %b need 10000101",
                         {respResult, respCarry, respOverflow, respZero, respNeg});
    end
    finish_resp();
    send(OP_NEG, 4'b0011, 4'b0111, lat);
    n_tests++;
    if ({respResult, respCarry, respOverflow, respZero, respNeg} !== 8'b1101_0001) begin
      n_fail++; $display("FAIL neg_3: got %b need 11010001",
                         {respResult, respCarry, respOverflow, respZero, respNeg});
    end
    finish_resp();
    send(OP_ABS, 4'b1011, 4'b0000, lat);
    n_tests++;
    if (lat !== 2) begin n_fail++; $display("FAIL abs_lat: got %0d need 2", lat); end
    n_tests++;
    if ({respResult, respCarry, respOverflow, respZero, respNeg} !== 8'b0101_0000) begin
      n_fail++; $display("FAIL abs_m5: got %b need 01010000",
                         {respResult, respCarry, respOverflow, respZero, respNeg});
    end
    finish_resp();
    send(OP_ABS, 4'b0000, 4'b0000, lat);
    n_tests++;
    if ({respResult, respCarry, respOverflow, respZero, respNeg} !== 8'b0000_0010) begin
      n_fail++; $display("FAIL abs_0: got %b need 00000010",
                         {respResult, respCarry, respOverflow, respZero, respNeg});
    end
    finish_resp();
    send(OP_ABS, 4'b0110, 4'b0000, lat);
    n_tests++;
    if ({respResult, respCarry, respOverflow, respZero, respNeg} !== 8'b0110_0000) begin
      n_fail++; $display("FAIL abs_6: got %b need 01100000",
                         {respResult, respCarry, respOverflow, respZero, respNeg});
    end
    finish_resp();
    n_tests++;
    if (opCount !== 8'd10) begin n_fail++; $display("FAIL cnt_after_unary: got %0d need 10", opCount); end
  endtask

  task automatic test_hold;
    int lat;
    respReady = 1'b0;
    send(OP_ADD, 4'b0111, 4'b0001, lat);
    n_tests++;
    if ({respResult, respCarry, respOverflow, respZero, respNeg} !== 8'b1000_0101) begin
      n_fail++; $display("FAIL hold_res: got %b need 10000101",
                         {respResult, respCarry, respOverflow, respZero, respNeg});
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin reqValid = 1'b1; reqOp = OP_NEG; reqA = 4'b0001; end
      @(posedge clock); #1;
      reqValid = 1'b0;
      n_tests++;
      if ({respValid, reqReady, respResult, respOverflow, opCount} !== {2'b10, 4'b1000, 1'b1, 8'd10}) begin
        n_fail++; $display("FAIL hold_cyc%0d: got vld %b rdy %b res %b v %b cnt %0d need 1 0 1000 1 10",
                           i, respValid, reqReady, respResult, respOverflow, opCount);
      end
    end
    finish_resp();
    n_tests++;
    if ({respValid, reqReady, opCount} !== {2'b01, 8'd11}) begin
      n_fail++; $display("FAIL hold_release: got vld %b rdy %b cnt %0d need 0 1 11", respValid, reqReady, opCount);
    end
    @(posedge clock); #1;
    n_tests++;
    if ({respValid, reqReady} !== 2'b01) begin
      n_fail++; $display("FAIL hold_noqueue: got vld %b rdy %b need 0 1", respValid, reqReady);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    respReady = 1'b1;
    reqValid = 1'b1; reqOp = OP_SUB; reqA = 4'b0011; reqB = 4'b0001;
    @(posedge clock); #1;
    reqValid = 1'b0;
    n_tests++;
    if ({respValid, reqReady} !== 2'b00) begin
      n_fail++; $display("FAIL mid_busy: got vld %b rdy %b need 0 0", respValid, reqReady);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if ({respValid, reqReady, respResult, respOverflow, respNeg, opCount} !== {2'b01, 4'b0000, 2'b00, 8'd0}) begin
      n_fail++; $display("FAIL mid_reset: got vld %b rdy %b res %b v %b n %b cnt %0d need 0 1 0000 0 0 0",
                         respValid, reqReady, respResult, respOverflow, respNeg, opCount);
    end
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;
    send(OP_ADD, 4'b0101, 4'b0010, lat);
    n_tests++;
    if ({lat[3:0], respResult, respCarry, respOverflow, respZero, respNeg} !== {4'd2, 8'b0111_0000}) begin
      n_fail++; $display("FAIL mid_after: got lat %0d res %b flags %b need 2 0111 0000",
                         lat, respResult, {respCarry, respOverflow, respZero, respNeg});
    end
    finish_resp();
    n_tests++;
    if (opCount !== 8'd1) begin n_fail++; $display("FAIL mid_cnt: got %0d need 1", opCount); end
  endtask

  task automatic test_back_to_back;
    int seen;
    int cyc;
    reset = 1'b1;
    #2;
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;
    respReady = 1'b1;
    reqValid = 1'b1; reqOp = OP_ADD; reqA = 4'b0001; reqB = 4'b0001;
    seen = 0; cyc = 0;
    while (seen < 256 && cyc < 1000) begin
      @(posedge clock); #1; cyc++;
      if (respValid) seen++;
    end
    n_tests++;
    if (cyc !== 767) begin n_fail++; $display("FAIL b2b_cycles: got %0d need 767", cyc); end
    n_tests++;
    if ({opCount, respResult} !== {8'd255, 4'b0010}) begin
      n_fail++; $display("FAIL b2b_255: got cnt %0d res %b need 255 0010", opCount, respResult);
    end
    reqValid = 1'b0;
    @(posedge clock); #1;
    n_tests++;
    if ({opCount, reqReady} !== {8'd0, 1'b1}) begin
      n_fail++; $display("FAIL b2b_wrap: got cnt %0d rdy %b need 0 1", opCount, reqReady);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_neg_abs();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu4_op_sequencer.md
Name: alu4_op_sequencer

Overview:
- Multi-cycle controller that sequences the team's 4-bit two's-complement negator and a 4-bit adder to execute ADD, SUB, NEG and ABS on 4-bit operands.
- Exactly one negator instance and one adder instance are shared across the steps of each operation.
- Requests arrive over a valid/ready handshake. Results leave over a valid/ready handshake with flags.
- Sits between the ALU's operand/opcode register stage and the result writeback.

Parameters:
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- reqValid  in  1  request present.
- reqReady  out  1  block can accept a request.
- reqOp  in  2  opcode: 00 ADD, 01 SUB, 10 NEG, 11 ABS.
- reqA  in  4  operand A, two's complement.
- reqB  in  4  operand B, two's complement; ignored for NEG and ABS.
- respValid  out  1  result available.
- respReady  in  1  consumer accepts result.
- respResult  out  4  result.
- respCarry  out  1  carry out of the 4-bit add; 0 for NEG and ABS.
- respOverflow  out  1  signed overflow.
- respZero  out  1  respResult == 0.
- respNeg  out  1  respResult[3].
- opCount  out  CNT_W  number of completed responses, wrapping.

Behaviour:
- States: IDLE, NEGATE, ADD, RESP. Reset state is IDLE.
- Reset values: reqReady=1 (combinational from IDLE); every other output and internal register is 0, including opCount.
- reqReady = (state==IDLE). A request is accepted on an edge where reqValid and reqReady are both 1. At acceptance, reqOp, reqA and reqB are latched.
- Transitions from IDLE on acceptance:
  - ADD goes to ADD.
  - SUB, NEG and ABS go to NEGATE.
- NEGATE:
  - Negator input is B for SUB and A for NEG/ABS.
  - SUB: the negator output is registered as the adder's second operand; next state is ADD.
  - NEG: result = neg(A); next state is RESP.
  - ABS: result = A[3] ? neg(A) : A; next state is RESP.
- ADD: sum = A + opB (opB is B for ADD, neg(B) for SUB). Result and flags are registered; next state is RESP.
- RESP: respValid=1. Result and flags are held stable until respReady=1. On that edge: state goes to IDLE and opCount increments, wrapping modulo 2^CNT_W.
- Latency from the acceptance edge to respValid high: ADD 2 edges, SUB 3, NEG 2, ABS 2.
- Flags:
  - ADD: carry = bit 4 of the 5-bit sum; overflow = (A[3]==B[3]) && (R[3]!=A[3]).
  - SUB: carry = bit 4 of A + neg(B); overflow = (A[3]!=B[3]) && (R[3]!=A[3]). This is the true signed overflow of A-B, including B=1000.
  - NEG and ABS: carry = 0; overflow = (A==4'b1000), and the result is 1000 in that case.
- Zero and negative are derived from the registered result.
- Boundaries:
  - No request is accepted outside IDLE, so the earliest back-to-back acceptance is the edge after the RESP handshake.
  - reqValid while busy is ignored, not queued.
  - respReady outside RESP is ignored.
  - Reset asserted mid-operation aborts the operation immediately (asynchronously). The in-flight request is lost, opCount clears, and respValid drops.
  - Reset release takes effect on the next clock edge, with the block in IDLE.

Decomposition:
- Shared package:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_NEG=2'b10, OP_ABS=2'b11;
  - state encoding for IDLE, NEGATE, ADD, RESP.
- Sub-modules:
  - the existing 4-bit two's-complement negator, instantiated once;
  - alu4_adder4, a new purely combinational 4-bit adder with 5-bit sum output.
- FSM, operand registers and flag logic live in alu4_op_sequencer.

Test Plan:
- Reset, then ADD A=0011 B=0100, respReady=1 → respValid 2 edges after acceptance, result 0111, C=0 V=0 Z=0 N=0, opCount=1.
- SUB A=0010 B=0101 → after 3 edges result 1101, V=0, N=1. Then SUB A=0000 B=1000 → result 1000, V=1.
- NEG A=1000 → result 1000, V=1. ABS A=1011 → result 0101, V=0, Z=0. ABS A=0000 → result 0000, Z=1.
- Hold respReady=0 for 5 cycles after an ADD 0111+0001 → result 1000 and V=1 held stable, reqReady=0, and a reqValid pulse during this window is not accepted.
- Assert reset while in NEGATE of a SUB → outputs immediately 0, reqReady=1, opCount=0. The next ADD after reset completes normally.
- 256 back-to-back ADDs → opCount wraps from 255 to 0.
